uart_led_cmd_parser: RTL
========================

# uart_led_cmd_parser

Byte-stream command parser sitting directly downstream of the UART receiver. It takes one-cycle received-byte strobes and assembles framed LED write commands of the form sync, address, R, G, B and optional checksum. On each valid frame it issues a single-cycle write strobe with LED address and 24-bit colour to the LED driver. Malformed, out-of-range and stalled frames are discarded, pulsed and counted.

## Interface
Parameters:
- CLK_HZ, 80000000, system clock frequency in Hz
- TIMEOUT_US, 1000, maximum inter-byte gap within a frame, in microseconds
- LED_COUNT, 64, number of addressable LEDs; valid addresses are 0..LED_COUNT-1
- SYNC_BYTE, 8'hAA, frame start marker

Ports:
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Valid  in  1  one-cycle strobe: i_Data holds a received byte
- i_Data  in  8  received byte
- o_Write  out  1  one-cycle strobe: o_Addr/o_RGB carry a validated command
- o_Addr  out  8  LED address of last accepted frame
- o_RGB  out  24  colour of last accepted frame, {R,G,B}
- o_Err  out  1  one-cycle pulse on frame rejection
- o_ErrCount  out  8  saturating count of rejected frames
- o_Idle  out  1  high while hunting for SYNC_BYTE

## Operation
- States: S_SYNC, S_ADDR, S_RED, S_GRN, S_BLU, S_CSUM (S_CSUM only with checksum build). Each advances on i_Valid only.
- S_SYNC: byte == SYNC_BYTE -> S_ADDR, clear running XOR; other bytes dropped silently, no error.
- S_ADDR/S_RED/S_GRN/S_BLU: latch byte into shadow register, XOR into 8-bit running checksum, advance.
- Final byte (S_BLU without checksum, S_CSUM with): frame valid if addr < LED_COUNT and (checksum disabled or byte == running XOR). Valid -> copy shadows to o_Addr/o_RGB, pulse o_Write. Invalid -> pulse o_Err, increment o_ErrCount. Either way -> S_SYNC.
- SYNC_BYTE inside a frame is data; no mid-frame resync.
- Timeout: 24-bit gap counter cleared on every i_Valid and in S_SYNC; counts otherwise. Reaching TIMEOUT_CYCLES-1 = CLK_HZ/1000000*TIMEOUT_US-1 outside S_SYNC -> S_SYNC, o_Err pulse, o_ErrCount increment, partial frame discarded.
- o_ErrCount saturates at 255; cleared only by reset.
- o_Idle = (state == S_SYNC), combinational from state register.

## Timing
- Reset values: o_Write 0, o_Addr 0, o_RGB 0, o_Err 0, o_ErrCount 0, o_Idle 1, state S_SYNC, gap counter 0, shadows 0.
- Latency: o_Write / o_Err asserted the cycle after the i_Valid carrying the final byte; o_Addr/o_RGB valid in that same cycle and held until the next accepted frame.
- Back-to-back i_Valid on consecutive cycles supported; no backpressure, no bytes lost.
- i_Valid in the same cycle the timeout would fire: byte wins, counter clears, no error.
- o_Write and o_Err never asserted together.
- i_Reset mid-frame: next cycle in S_SYNC, all outputs at reset values, partial frame dropped, no o_Err.

## Configuration
- UART_CMD_CHECKSUM_EN defined: frame is 6 bytes; S_CSUM present; 6th byte must equal addr^R^G^B, else rejected.
- Undefined: frame is 5 bytes; S_CSUM and XOR logic removed; validity is the address range check only.

## Test plan
- Checksum build, bytes AA 05 12 34 56 75 -> o_Write one cycle after 0x75, o_Addr=0x05, o_RGB=0x123456, o_Err never high.
- Checksum build, AA 05 12 34 56 00 -> no o_Write, single o_Err pulse, o_ErrCount=1, o_Idle=1.
- Address 0x40 with LED_COUNT=64 (AA 40 01 02 03 + csum 0x40) -> o_Err pulse, o_Addr/o_RGB unchanged from prior values.
- AA 05 12 then idle for TIMEOUT_CYCLES -> o_Err pulse at expiry, o_Idle=1; a following valid frame writes normally.
- Garbage 00 FF 55 AA-less stream then a valid frame -> exactly one o_Write, o_ErrCount unchanged; 300 bad frames -> o_ErrCount holds 255.
- i_Reset asserted after AA 05 12 -> outputs at reset values, no o_Err; next full frame accepted.

Source files
------------

// File: rtl/uart_led_cmd_parser.sv
// uart_led_cmd_parser
//
// Assembles framed LED write commands from a UART receive byte stream.
// A frame is SYNC_BYTE, address, R, G and B, plus a trailing checksum byte
// (addr ^ R ^ G ^ B) when UART_CMD_CHECKSUM_EN is defined. A valid frame
// produces a one-cycle o_Write. A frame with an out-of-range address, a bad
// checksum or an inter-byte gap that is too long produces a one-cycle o_Err
// and increments a saturating error counter.
//
// Build option: UART_CMD_CHECKSUM_EN adds the checksum byte. The default
// build uses 5-byte frames with only the address range check.
//
// Ports:
//   i_Clock     system clock, rising edge
//   i_Reset     synchronous active-high reset
//   i_Valid     one-cycle strobe, i_Data holds a received byte
//   i_Data      received byte
//   o_Write     one-cycle strobe, o_Addr/o_RGB carry an accepted command
//   o_Addr      LED address of the last accepted frame
//   o_RGB       {R,G,B} of the last accepted frame
//   o_Err       one-cycle pulse when a frame is rejected
//   o_ErrCount  saturating count of rejected frames
//   o_Idle      high while hunting for SYNC_BYTE
module uart_led_cmd_parser #(
  parameter int unsigned CLK_HZ     = 80000000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned LED_COUNT  = 64,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic [7:0]  i_Data,
  output logic        o_Write,
  output logic [7:0]  o_Addr,
  output logic [23:0] o_RGB,
  output logic        o_Err,
  output logic [7:0]  o_ErrCount,
  output logic        o_Idle
);

  localparam int unsigned TimeoutCycles = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam logic [23:0] GapLast       = 24'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StSync,
    StAddr,
    StRed,
    StGrn,
`ifdef UART_CMD_CHECKSUM_EN
    StBlu,
    StCsum
`else
    StBlu
`endif
  } state_e;

  state_e      state_q;
  logic [23:0] gap_q;
  logic [7:0]  addr_q;
  logic [7:0]  red_q;
  logic [7:0]  grn_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  blu_q;
  logic [7:0]  csum_q;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign o_Idle = (state_q == StSync);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= StSync;
      gap_q      <= '0;
      addr_q     <= '0;
      red_q      <= '0;
      grn_q      <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      blu_q      <= '0;
      csum_q     <= '0;
`endif
      o_Write    <= 1'b0;
      o_Addr     <= '0;
      o_RGB      <= '0;
      o_Err      <= 1'b0;
      o_ErrCount <= '0;
    end else begin
      o_Write <= 1'b0;
      o_Err   <= 1'b0;

      if (state_q == StSync || i_Valid) begin
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + 24'd1;
      end

      if (i_Valid) begin
        unique case (state_q)
          StSync: begin
            if (i_Data == SYNC_BYTE) begin
              state_q <= StAddr;
`ifdef UART_CMD_CHECKSUM_EN
              csum_q  <= '0;
`endif
            end
          end
          StAddr: begin
            addr_q  <= i_Data;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q  <= csum_q ^ i_Data;
`endif
            state_q <= StRed;
          end
          StRed: begin
            red_q   <= i_Data;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q  <= csum_q ^ i_Data;
`endif
            state_q <= StGrn;
          end
          StGrn: begin
            grn_q   <= i_Data;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q  <= csum_q ^ i_Data;
`endif
            state_q <= StBlu;
          end
`ifdef UART_CMD_CHECKSUM_EN
          StBlu: begin
            blu_q   <= i_Data;
            csum_q  <= csum_q ^ i_Data;
            state_q <= StCsum;
          end
          StCsum: begin
            if (32'(addr_q) < LED_COUNT && i_Data == csum_q) begin
              o_Addr  <= addr_q;
              o_RGB   <= {red_q, grn_q, blu_q};
              o_Write <= 1'b1;
            end else begin
              o_Err      <= 1'b1;
              o_ErrCount <= sat_inc(o_ErrCount);
            end
            state_q <= StSync;
          end
`else
          StBlu: begin
            if (32'(addr_q) < LED_COUNT) begin
              o_Addr  <= addr_q;
              o_RGB   <= {red_q, grn_q, i_Data};
              o_Write <= 1'b1;
            end else begin
              o_Err      <= 1'b1;
              o_ErrCount <= sat_inc(o_ErrCount);
            end
            state_q <= StSync;
          end
`endif
          default: state_q <= StSync;
        endcase
      end else if (state_q != StSync && gap_q == GapLast) begin
        // Inter-byte gap expired: drop the partial frame.
        state_q    <= StSync;
        o_Err      <= 1'b1;
        o_ErrCount <= sat_inc(o_ErrCount);
      end
    end
  end

endmodule
